// File: rtl/display_driver.sv
// HUB75 scan driver: fetches RGB888 pixels, PWM-compares them per pass, shifts them out with oclk/lat/oe.
// Build option DISPLAY_DRIVER_OE_ACTIVE_LOW_EN inverts the oe port for panels with active-low OE.
module display_driver #(
  parameter int unsigned SEGMENTS = 1,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLUMNS  = 32,
  parameter int unsigned BITWIDTH = 8,
  localparam int unsigned ROW_W   = (ROWS * SEGMENTS > 1) ? $clog2(ROWS * SEGMENTS) : 1,
  localparam int unsigned COL_W   = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  frame_complete,
  output logic [ROW_W-1:0]      row,
  output logic [COL_W-1:0]      column,
  input  logic [23:0]           pixel,
  output logic [3*SEGMENTS-1:0] rgb,
  output logic                  oe,
  output logic                  lat,
  output logic                  oclk
);

  // One column slot: rgb settles, oclk high, oclk low; widened so every segment fetch lands in it.
  localparam int unsigned PHASES = (SEGMENTS + 1 > 3) ? SEGMENTS + 1 : 3;
  localparam int unsigned PH_W   = $clog2(PHASES);
  localparam int unsigned R_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned K_W    = BITWIDTH + 1;
  localparam int unsigned KMAX   = 1 << BITWIDTH;
  localparam int unsigned TOP    = KMAX - 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLUMNS - 1);
  localparam logic [R_W-1:0]   ROW_LAST = R_W'(ROWS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(KMAX);

`ifdef DISPLAY_DRIVER_OE_ACTIVE_LOW_EN
  localparam logic OE_OFF = 1'b1;
`else
  localparam logic OE_OFF = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FILL,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_FRAME
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [R_W-1:0]          r_q, r_d;
  logic [3*SEGMENTS-1:0]   stage_q, stage_d;
  logic [3*SEGMENTS-1:0]   rgb_q, rgb_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        column_q, column_d;
  logic                    oe_q, oe_d;
  logic                    lat_q, lat_d;
  logic                    oclk_q, oclk_d;
  logic                    frame_complete_q, frame_complete_d;

  logic                    last_ph;
  logic                    fetch_cur;
  logic                    fetch_nxt;
  logic                    lit_nxt;
  logic [K_W-1:0]          thr;
  logic [2:0]              pwm_bits;

  always_comb begin
    state_d          = state_q;
    ph_d             = ph_q;
    col_d            = col_q;
    k_d              = k_q;
    r_d              = r_q;
    stage_d          = stage_q;
    rgb_d            = rgb_q;
    row_d            = row_q;
    column_d         = column_q;
    oe_d             = OE_OFF;
    lat_d            = 1'b0;
    oclk_d           = 1'b0;
    frame_complete_d = 1'b0;

    last_ph = (ph_q == PH_LAST);

    case (state_q)
      S_FILL: begin
        if (last_ph) begin
          state_d = S_SHIFT;
          ph_d    = '0;
          col_d   = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SHIFT: begin
        if (!last_ph) begin
          ph_d = ph_q + PH_W'(1);
        end else begin
          ph_d = '0;
          if (col_q != COL_LAST) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            if (k_q != K_LAST) begin
              state_d = S_BLANK;
            end else begin
              // Dummy pass done: no latch, move on to the next scan row.
              k_d = '0;
              if (r_q == ROW_LAST) begin
                r_d     = '0;
                state_d = S_FRAME;
              end else begin
                r_d     = r_q + R_W'(1);
                state_d = S_FILL;
              end
            end
          end
        end
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_FILL;
        k_d     = k_q + K_W'(1);
      end
      S_FRAME: state_d = S_FILL;
      default: state_d = S_FILL;
    endcase

    // Capture: pixel for segment s arrives in phase s+1 of a slot that was fetching.
    fetch_cur = (state_q == S_FILL) || ((state_q == S_SHIFT) && (col_q != COL_LAST));
    thr       = (k_q >= K_W'(TOP)) ? K_W'(TOP) : k_q + K_W'(1);
    pwm_bits  = {({1'b0, pixel[23 -: BITWIDTH]} >= thr),
                 ({1'b0, pixel[15 -: BITWIDTH]} >= thr),
                 ({1'b0, pixel[7  -: BITWIDTH]} >= thr)};
    for (int s = 0; s < int'(SEGMENTS); s++) begin
      if (fetch_cur && (ph_q == PH_W'(s + 1))) begin
        stage_d[3*s +: 3] = pwm_bits;
      end
    end
    if (fetch_cur && last_ph) begin
      rgb_d = stage_d;
    end

    // Address for the next cycle: prefetch column col+1 (or 0 while filling), one segment per phase.
    fetch_nxt = (state_d == S_FILL) || ((state_d == S_SHIFT) && (col_d != COL_LAST));
    if (fetch_nxt && (ph_d < PH_W'(SEGMENTS))) begin
      row_d    = ROW_W'(ph_d) * ROW_W'(ROWS) + ROW_W'(r_d);
      column_d = (state_d == S_FILL) ? '0 : col_d + COL_W'(1);
    end else begin
      row_d = ROW_W'(r_d);
    end

    lit_nxt          = ((state_d == S_FILL) || (state_d == S_SHIFT)) && (k_d != '0);
    oe_d             = lit_nxt ? ~OE_OFF : OE_OFF;
    lat_d            = (state_d == S_LATCH);
    oclk_d           = (state_d == S_SHIFT) && (ph_d == PH_W'(1));
    frame_complete_d = (state_d == S_FRAME);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_FILL;
      ph_q             <= '0;
      col_q            <= '0;
      k_q              <= '0;
      r_q              <= '0;
      stage_q          <= '0;
      rgb_q            <= '0;
      row_q            <= '0;
      column_q         <= '0;
      oe_q             <= OE_OFF;
      lat_q            <= 1'b0;
      oclk_q           <= 1'b0;
      frame_complete_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      ph_q             <= ph_d;
      col_q            <= col_d;
      k_q              <= k_d;
      r_q              <= r_d;
      stage_q          <= stage_d;
      rgb_q            <= rgb_d;
      row_q            <= row_d;
      column_q         <= column_d;
      oe_q             <= oe_d;
      lat_q            <= lat_d;
      oclk_q           <= oclk_d;
      frame_complete_q <= frame_complete_d;
    end
  end

  assign frame_complete = frame_complete_q;
  assign row            = row_q;
  assign column         = column_q;
  assign rgb            = rgb_q;
  assign oe             = oe_q;
  assign lat            = lat_q;
  assign oclk           = oclk_q;

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: frame-memory model plus an event-level reference of the scan sequence.
module tb_display_driver;

  localparam int SEG   = 2;
  localparam int ROWS  = 2;
  localparam int COLS  = 8;
  localparam int BW    = 8;
  localparam int KMAX  = 1 << BW;
  localparam int ROW_W = 2;
  localparam int COL_W = 3;

`ifdef DISPLAY_DRIVER_OE_ACTIVE_LOW_EN
  localparam logic OE_LOW = 1'b1;
`else
  localparam logic OE_LOW = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 frame_complete;
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     column;
  logic [23:0]          pixel;
  logic [3*SEG-1:0]     rgb;
  logic                 oe;
  logic                 lat;
  logic                 oclk;

  logic [23:0] mem [SEG*ROWS][COLS];

  int checks = 0;
  int errors = 0;

  int exp_r, exp_k, exp_col, lat_cnt, frames;
  bit fc_seen;
  logic oclk_p, lat_p, fc_p, lit_p;
  logic [3*SEG-1:0] rgb_p, rgb_rise;

  display_driver #(
    .SEGMENTS(SEG),
    .ROWS(ROWS),
    .COLUMNS(COLS),
    .BITWIDTH(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_complete(frame_complete),
    .row(row),
    .column(column),
    .pixel(pixel),
    .rgb(rgb),
    .oe(oe),
    .lat(lat),
    .oclk(oclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous frame memory: data one clock after the address.
  always @(posedge clk) pixel <= mem[row][column];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lane bits: a channel is lit when value >= min(k+1, max).
  function automatic logic [3*SEG-1:0] model_rgb(input int r, input int k, input int c);
    logic [3*SEG-1:0] v;
    logic [23:0] px;
    int t;
    t = (k + 1 < KMAX - 1) ? k + 1 : KMAX - 1;
    for (int s = 0; s < SEG; s++) begin
      px = mem[s*ROWS + r][c];
      v[3*s+2] = (int'(px[23:16]) >> (8 - BW)) >= t;
      v[3*s+1] = (int'(px[15:8])  >> (8 - BW)) >= t;
      v[3*s]   = (int'(px[7:0])   >> (8 - BW)) >= t;
    end
    return v;
  endfunction

  function automatic logic [7:0] rand_ch();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h01;
      3: return 8'hFE;
      4: return 8'h80;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic monitor();
    logic lit;
    lit = oe ^ OE_LOW;
    if (rst) begin
      chk("reset_outputs", 32'({frame_complete, lat, oclk, lit, row, column, rgb}), 32'd0);
      exp_r = 0; exp_k = 0; exp_col = 0; lat_cnt = 0;
    end else begin
      chk("lat_with_oclk", 32'(lat & oclk), 32'd0);
      chk("lat_while_lit", 32'(lat & lit), 32'd0);
      chk("oclk_width", 32'(oclk & oclk_p), 32'd0);
      chk("lat_width", 32'(lat & lat_p), 32'd0);
      chk("fc_width", 32'(frame_complete & fc_p), 32'd0);
      if (oclk && !oclk_p) begin
        if (exp_col == COLS && exp_k == KMAX && exp_r != ROWS - 1) begin
          chk("lat_per_row", 32'(lat_cnt), 32'(KMAX));
          lat_cnt = 0; exp_r++; exp_k = 0; exp_col = 0;
        end
        chk("oclk_per_pass", 32'(exp_col < COLS), 32'd1);
        chk("row_addr", 32'(int'(row) % ROWS), 32'(exp_r));
        chk("oe_during_shift", 32'(lit), 32'(exp_k != 0));
        chk("rgb_setup", 32'(rgb), 32'(rgb_p));
        if (exp_col < COLS) chk("rgb_data", 32'(rgb), 32'(model_rgb(exp_r, exp_k, exp_col)));
        rgb_rise = rgb;
        exp_col++;
      end
      if (!oclk && oclk_p) chk("rgb_hold", 32'(rgb), 32'(rgb_rise));
      if (lat) begin
        chk("lat_after_cols", 32'(exp_col), 32'(COLS));
        chk("lat_in_dummy_pass", 32'(exp_k == KMAX), 32'd0);
        chk("blank_before_lat", 32'(oclk_p | lit_p), 32'd0);
        exp_k++; exp_col = 0; lat_cnt++;
      end
      if (!lat && lat_p) chk("oe_after_lat", 32'(lit), 32'd1);
      if (frame_complete) begin
        chk("fc_frame_end", 32'({exp_r == ROWS - 1, exp_k == KMAX, exp_col == COLS}), 32'b111);
        chk("fc_outputs_quiet", 32'({lat, lit, oclk}), 32'd0);
        chk("lat_per_last_row", 32'(lat_cnt), 32'(KMAX));
        exp_r = 0; exp_k = 0; exp_col = 0; lat_cnt = 0;
        fc_seen = 1'b1;
        frames++;
      end
    end
    oclk_p = oclk; lat_p = lat; fc_p = frame_complete; lit_p = lit; rgb_p = rgb;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_frame(input int limit, input string tag);
    int n;
    n = 0;
    fc_seen = 1'b0;
    while (!fc_seen && n < limit) begin
      step();
      n++;
    end
    chk(tag, 32'(fc_seen), 32'd1);
  endtask

  initial begin
    exp_r = 0; exp_k = 0; exp_col = 0; lat_cnt = 0; frames = 0; fc_seen = 1'b0;
    oclk_p = 1'b0; lat_p = 1'b0; fc_p = 1'b0; lit_p = 1'b0; rgb_p = '0; rgb_rise = '0;

    // Single lit pixel at segment 0, row 0, column 0.
    for (int a = 0; a < SEG*ROWS; a++)
      for (int c = 0; c < COLS; c++) mem[a][c] = 24'h000000;
    mem[0][0] = 24'hFF0000;

    rst = 1'b1;
    repeat (3) step();
    chk("reset_oe_idle", 32'(oe), 32'(OE_LOW));
    rst = 1'b0;
    wait_frame(20000, "frame1_complete");

    // Mid-scale grey levels: lit only while threshold <= 128.
    for (int a = 0; a < SEG*ROWS; a++)
      for (int c = 0; c < COLS; c++) mem[a][c] = 24'h000000;
    mem[0][3] = 24'h800000;
    mem[1][7] = 24'h008000;
    mem[2][0] = 24'h000080;
    mem[3][5] = 24'h7F80FF;
    wait_frame(20000, "frame2_complete");

    // Random content weighted toward the boundary codes.
    for (int a = 0; a < SEG*ROWS; a++)
      for (int c = 0; c < COLS; c++) mem[a][c] = {rand_ch(), rand_ch(), rand_ch()};
    wait_frame(20000, "frame3_complete");
    chk("frame_count", 32'(frames), 32'd3);

    // Reset while shifting: outputs clear at once, scan restarts at row 0 pass 0.
    repeat (700) step();
    begin
      int n;
      n = 0;
      while (!oclk && n < 50) begin
        step();
        n++;
      end
      chk("found_shift_for_reset", 32'(oclk), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({frame_complete, lat, oclk, oe ^ OE_LOW, row, column, rgb}), 32'd0);
    repeat (4) step();
    rst = 1'b0;
    repeat (2500) step();
    chk("restart_row0", 32'(exp_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
